// File: rtl/rv32i_lsu_pkg.sv
// -----------------------------------------------------------------------------
// rv32i_lsu_pkg
//
// Shared encodings for the rv32i load/store unit. These are the same memory
// operation, read-type and write-mask codes the core's decoder emits. They are
// collected here so the LSU, its alignment helper and the bench all import one
// definition.
//
// Contents:
//   MEM_OP_*   2-bit memory operation selector (none / load / store)
//   MEM_RD_*   3-bit load type (funct3 encoding: signed at 0..2, unsigned at 4..5)
//   MEM_WR_*   4-bit unshifted store byte mask
//   lsu_ctx_t  per-access context latched when a request is issued
// -----------------------------------------------------------------------------
package rv32i_lsu_pkg;

    localparam logic [1:0] MEM_OP_NONE  = 2'd0;
    localparam logic [1:0] MEM_OP_LOAD  = 2'd1;
    localparam logic [1:0] MEM_OP_STORE = 2'd2;

    localparam logic [2:0] MEM_RD_BYTE = 3'd0;
    localparam logic [2:0] MEM_RD_HALF = 3'd1;
    localparam logic [2:0] MEM_RD_WORD = 3'd2;
    localparam logic [2:0] MEM_RD_B_U  = 3'd4;
    localparam logic [2:0] MEM_RD_H_U  = 3'd5;

    localparam logic [3:0] MEM_WR_BYTE = 4'b0001;
    localparam logic [3:0] MEM_WR_HALF = 4'b0011;
    localparam logic [3:0] MEM_WR_WORD = 4'b1111;

    // What the WAIT state needs to finish a load once memory answers.
    typedef struct packed {
        logic       is_load;
        logic [2:0] rd_type;
        logic [1:0] addr_lo;
    } lsu_ctx_t;

endpackage : rv32i_lsu_pkg

// File: rtl/rv32i_lsu_if.sv
// -----------------------------------------------------------------------------
// rv32i_lsu_if
//
// Data memory port between the LSU (master) and the data memory (slave).
// A request is held on req/addr/wmask/write until the memory raises valid for
// one cycle; for loads, read carries the addressed word in that same cycle.
//
// Signals:
//   data_mem_req    master->slave  access request
//   data_mem_addr   master->slave  word-aligned byte address, DMEM_WIDTH bits
//   data_mem_wmask  master->slave  byte write enables (0 for loads)
//   data_mem_write  master->slave  lane-shifted store data (0 for loads)
//   data_mem_read   slave->master  read word
//   data_mem_valid  slave->master  load data valid / store committed
// -----------------------------------------------------------------------------
interface rv32i_lsu_if #(
    parameter int DMEM_WIDTH = 16
);

    logic                  data_mem_req;
    logic [DMEM_WIDTH-1:0] data_mem_addr;
    logic [3:0]            data_mem_wmask;
    logic [31:0]           data_mem_write;
    logic [31:0]           data_mem_read;
    logic                  data_mem_valid;

    modport master (
        output data_mem_req,
        output data_mem_addr,
        output data_mem_wmask,
        output data_mem_write,
        input  data_mem_read,
        input  data_mem_valid
    );

    modport slave (
        input  data_mem_req,
        input  data_mem_addr,
        input  data_mem_wmask,
        input  data_mem_write,
        output data_mem_read,
        output data_mem_valid
    );

endinterface : rv32i_lsu_if

// File: rtl/rv32i_lsu_dmem_align.sv
// -----------------------------------------------------------------------------
// rv32i_lsu_dmem_align
//
// Purely combinational byte-lane logic for the LSU.
//   - Store side: shifts store data and byte mask into the lanes selected by
//     the low address bits of the incoming request.
//   - Load side: shifts the returned word down by the latched byte offset and
//     sign- or zero-extends it according to the latched load type.
//   - Flags a misaligned incoming request (halfword on an odd address, word on
//     any non-multiple of four). Byte accesses are never misaligned.
//
// Ports:
//   op_i, rd_type_i, wr_mask_i, addr_lo_i, wdata_i   incoming request (IDLE)
//   ld_type_i, ld_addr_lo_i, rword_i                 latched load + memory word
//   st_wmask_o, st_wdata_o                           lane-aligned store outputs
//   ld_data_o                                        extended load result
//   misaligned_o                                     incoming request misaligned
// -----------------------------------------------------------------------------
module rv32i_lsu_dmem_align
    import rv32i_lsu_pkg::*;
(
    input  logic [1:0]  op_i,
    input  logic [2:0]  rd_type_i,
    input  logic [3:0]  wr_mask_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [2:0]  ld_type_i,
    input  logic [1:0]  ld_addr_lo_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  st_wmask_o,
    output logic [31:0] st_wdata_o,
    output logic [31:0] ld_data_o,
    output logic        misaligned_o
);

    logic [31:0] ld_shifted;

    assign st_wdata_o = wdata_i << {addr_lo_i, 3'b000};
    assign st_wmask_o = wr_mask_i << addr_lo_i;
    assign ld_shifted = rword_i >> {ld_addr_lo_i, 3'b000};

    // NOTE: every output of an always_comb gets a default before the case so
    // that an unlisted encoding cannot leave it unassigned and infer a latch.
    always_comb begin
        ld_data_o = ld_shifted;
        unique case (ld_type_i)
            MEM_RD_BYTE: ld_data_o = {{24{ld_shifted[7]}}, ld_shifted[7:0]};
            MEM_RD_B_U:  ld_data_o = {24'h000000, ld_shifted[7:0]};
            MEM_RD_HALF: ld_data_o = {{16{ld_shifted[15]}}, ld_shifted[15:0]};
            MEM_RD_H_U:  ld_data_o = {16'h0000, ld_shifted[15:0]};
            default:     ld_data_o = ld_shifted;
        endcase
    end

    // Loads are judged by their read type, stores by their write mask; the
    // other field is don't-care for that operation.
    always_comb begin
        misaligned_o = 1'b0;
        if (op_i == MEM_OP_LOAD) begin
            unique case (rd_type_i)
                MEM_RD_HALF, MEM_RD_H_U: misaligned_o = addr_lo_i[0];
                MEM_RD_WORD:             misaligned_o = (addr_lo_i != 2'b00);
                default:                 misaligned_o = 1'b0;
            endcase
        end else if (op_i == MEM_OP_STORE) begin
            unique case (wr_mask_i)
                MEM_WR_HALF: misaligned_o = addr_lo_i[0];
                MEM_WR_WORD: misaligned_o = (addr_lo_i != 2'b00);
                default:     misaligned_o = 1'b0;
            endcase
        end
    end

endmodule : rv32i_lsu_dmem_align

// File: rtl/rv32i_lsu.sv
// -----------------------------------------------------------------------------
// rv32i_lsu
//
// Load/store unit between the core FSM and the data memory. Accepts one access
// per start pulse while idle, issues it on the data memory port and holds the
// request until the memory acknowledges or a bounded wait expires. Every
// access, including no-ops and rejected misaligned ones, ends with a one-cycle
// done pulse; the core raises any trap from the held misaligned/timeout flags.
//
// Parameters:
//   DMEM_WIDTH  data memory address width in bits
//   MAX_WAIT    extra wait cycles tolerated before timeout (0..255)
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   start_i                    access request, sampled only in IDLE
//   mem_op_i                   MEM_OP_NONE / LOAD / STORE
//   mem_read_type_i            MEM_RD_* load type
//   mem_write_mask_i           unshifted MEM_WR_* store mask
//   addr_i                     effective byte address
//   wdata_i                    right-aligned store data
//   busy_o                     access in flight on the memory port
//   done_o                     one-cycle completion pulse
//   rdata_o                    extended load result, held until next start
//   misaligned_o, timeout_o    completion status, held until next start
//   dmem                       data memory port (master side)
// -----------------------------------------------------------------------------
module rv32i_lsu
    import rv32i_lsu_pkg::*;
#(
    parameter int DMEM_WIDTH = 16,
    parameter int MAX_WAIT   = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start_i,
    input  logic [1:0]         mem_op_i,
    input  logic [2:0]         mem_read_type_i,
    input  logic [3:0]         mem_write_mask_i,
    input  logic [31:0]        addr_i,
    input  logic [31:0]        wdata_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [31:0]        rdata_o,
    output logic               misaligned_o,
    output logic               timeout_o,
    rv32i_lsu_if.master        dmem
);

    localparam int CNT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e                state_q;
    lsu_ctx_t              ctx_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  busy_q;
    logic                  done_q;
    logic [31:0]           rdata_q;
    logic                  misaligned_q;
    logic                  timeout_q;
    logic                  req_q;
    logic [DMEM_WIDTH-1:0] addr_q;
    logic [3:0]            wmask_q;
    logic [31:0]           write_q;

    logic [3:0]            st_wmask;
    logic [31:0]           st_wdata;
    logic [31:0]           ld_data;
    logic                  req_misaligned;

    rv32i_lsu_dmem_align u_align (
        .op_i         (mem_op_i),
        .rd_type_i    (mem_read_type_i),
        .wr_mask_i    (mem_write_mask_i),
        .addr_lo_i    (addr_i[1:0]),
        .wdata_i      (wdata_i),
        .ld_type_i    (ctx_q.rd_type),
        .ld_addr_lo_i (ctx_q.addr_lo),
        .rword_i      (dmem.data_mem_read),
        .st_wmask_o   (st_wmask),
        .st_wdata_o   (st_wdata),
        .ld_data_o    (ld_data),
        .misaligned_o (req_misaligned)
    );

    // Memory is smaller than the 32-bit address space; the upper bits of the
    // effective address are deliberately dropped.
    if (DMEM_WIDTH < 32) begin : g_addr_trunc
        logic unused_addr_hi;
        assign unused_addr_hi = ^addr_i[31:DMEM_WIDTH];
    end

    // NOTE: all state lives in one clocked block using non-blocking
    // assignments, so every register samples the pre-edge value of every
    // other register regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            ctx_q        <= '0;
            cnt_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            rdata_q      <= '0;
            misaligned_q <= 1'b0;
            timeout_q    <= 1'b0;
            req_q        <= 1'b0;
            addr_q       <= '0;
            wmask_q      <= '0;
            write_q      <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        misaligned_q <= 1'b0;
                        timeout_q    <= 1'b0;
                        if (mem_op_i == MEM_OP_NONE) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else if (req_misaligned) begin
                            // Rejected before touching memory; the core traps.
                            state_q      <= ST_DONE;
                            done_q       <= 1'b1;
                            misaligned_q <= 1'b1;
                        end else begin
                            state_q       <= ST_WAIT;
                            busy_q        <= 1'b1;
                            req_q         <= 1'b1;
                            cnt_q         <= '0;
                            ctx_q.is_load <= (mem_op_i == MEM_OP_LOAD);
                            ctx_q.rd_type <= mem_read_type_i;
                            ctx_q.addr_lo <= addr_i[1:0];
                            addr_q        <= {addr_i[DMEM_WIDTH-1:2], 2'b00};
                            if (mem_op_i == MEM_OP_STORE) begin
                                wmask_q <= st_wmask;
                                write_q <= st_wdata;
                            end else begin
                                wmask_q <= 4'b0000;
                                write_q <= '0;
                            end
                        end
                    end
                end

                ST_WAIT: begin
                    // An ack on the last allowed cycle still wins over timeout.
                    if (dmem.data_mem_valid || (cnt_q == CNT_MAX)) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        req_q   <= 1'b0;
                        wmask_q <= 4'b0000;
                        write_q <= '0;
                        if (dmem.data_mem_valid) begin
                            if (ctx_q.is_load) begin
                                rdata_q <= ld_data;
                            end
                        end else begin
                            timeout_q <= 1'b1;
                            rdata_q   <= '0;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                ST_DONE: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                end

                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    req_q   <= 1'b0;
                    wmask_q <= 4'b0000;
                    write_q <= '0;
                end
            endcase
        end
    end

    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign rdata_o        = rdata_q;
    assign misaligned_o   = misaligned_q;
    assign timeout_o      = timeout_q;

    assign dmem.data_mem_req   = req_q;
    assign dmem.data_mem_addr  = addr_q;
    assign dmem.data_mem_wmask = wmask_q;
    assign dmem.data_mem_write = write_q;

endmodule : rv32i_lsu

// File: tb/tb_rv32i_lsu.sv
// -----------------------------------------------------------------------------
// tb_rv32i_lsu
//
// Directed bench for rv32i_lsu with DMEM_WIDTH=16 and MAX_WAIT=3. A table of
// accesses (inputs, memory answer delay, expected outputs) is replayed through
// one transaction task; reset-mid-access and valid-while-idle are covered by
// short hand-written sequences. Inputs change and outputs are sampled on the
// falling clock edge.
// -----------------------------------------------------------------------------
module tb_rv32i_lsu;
    import rv32i_lsu_pkg::*;

    localparam int DW    = 16;
    localparam int MW    = 3;
    localparam int NEVER = 99;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  mem_op;
    logic [2:0]  mem_read_type;
    logic [3:0]  mem_write_mask;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] rdata;
    logic        misaligned;
    logic        timeout;

    int n_cmp = 0;
    int n_err = 0;

    rv32i_lsu_if #(.DMEM_WIDTH(DW)) mem_if ();

    rv32i_lsu #(.DMEM_WIDTH(DW), .MAX_WAIT(MW)) dut (
        .clk              (clk),
        .reset            (reset),
        .start_i          (start),
        .mem_op_i         (mem_op),
        .mem_read_type_i  (mem_read_type),
        .mem_write_mask_i (mem_write_mask),
        .addr_i           (addr),
        .wdata_i          (wdata),
        .busy_o           (busy),
        .done_o           (done),
        .rdata_o          (rdata),
        .misaligned_o     (misaligned),
        .timeout_o        (timeout),
        .dmem             (mem_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [2:0]  rt;
        logic [3:0]  wm;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] word;      // memory answer
        int          wait_n;    // req cycle index carrying valid (NEVER = none)
        bit          spam;      // re-pulse start while the access is busy
        int          e_lat;     // cycles from accept edge to done
        int          e_req;     // req-high cycles
        logic [15:0] e_addr;
        logic [3:0]  e_wmask;
        logic [31:0] e_write;
        bit          e_misal;
        bit          e_to;
        bit          chk_rd;
        logic [31:0] e_rdata;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic [1:0] op, input logic [2:0] rt, input logic [3:0] wm,
        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] word,
        input int wait_n, input bit spam, input int e_lat, input int e_req,
        input logic [15:0] e_addr, input logic [3:0] e_wmask,
        input logic [31:0] e_write, input bit e_misal, input bit e_to,
        input bit chk_rd, input logic [31:0] e_rdata);
        vec_t v;
        v.op = op; v.rt = rt; v.wm = wm; v.addr = a; v.wdata = wd; v.word = word;
        v.wait_n = wait_n; v.spam = spam; v.e_lat = e_lat; v.e_req = e_req;
        v.e_addr = e_addr; v.e_wmask = e_wmask; v.e_write = e_write;
        v.e_misal = e_misal; v.e_to = e_to; v.chk_rd = chk_rd; v.e_rdata = e_rdata;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int          lat;
        int          nreq;
        bit          stable;
        bit          busy_ok;
        logic [15:0] a0;
        logic [3:0]  m0;
        logic [31:0] w0;
        string       tag;
        tag = $sformatf("v%0d", idx);
        a0 = '0; m0 = '0; w0 = '0;
        @(negedge clk);
        start = 1'b1; mem_op = v.op; mem_read_type = v.rt;
        mem_write_mask = v.wm; addr = v.addr; wdata = v.wdata;
        @(negedge clk);
        start = 1'b0;
        lat = 1; nreq = 0; stable = 1'b1; busy_ok = 1'b1;
        while (!done && lat < 40) begin
            if (mem_if.data_mem_req) begin
                if (nreq == 0) begin
                    a0 = mem_if.data_mem_addr; m0 = mem_if.data_mem_wmask;
                    w0 = mem_if.data_mem_write;
                end else if (mem_if.data_mem_addr !== a0 ||
                             mem_if.data_mem_wmask !== m0 ||
                             mem_if.data_mem_write !== w0) begin
                    stable = 1'b0;
                end
                if (busy !== 1'b1) busy_ok = 1'b0;
                if (v.spam) begin
                    start = 1'b1; mem_op = MEM_OP_STORE;
                    mem_write_mask = MEM_WR_WORD; addr = 32'h0000_0040;
                end
                if (nreq == v.wait_n) begin
                    mem_if.data_mem_valid = 1'b1;
                    mem_if.data_mem_read  = v.word;
                end
                nreq++;
            end
            @(negedge clk);
            start = 1'b0;
            mem_if.data_mem_valid = 1'b0;
            mem_if.data_mem_read  = 32'hDEAD_0000 | 32'(lat);
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'(v.e_lat));
        check({tag, " req_cycles"}, 32'(nreq), 32'(v.e_req));
        check({tag, " busy_at_done"}, 32'(busy), 32'd0);
        check({tag, " misaligned"}, 32'(misaligned), 32'(v.e_misal));
        check({tag, " timeout"}, 32'(timeout), 32'(v.e_to));
        if (v.chk_rd) check({tag, " rdata"}, rdata, v.e_rdata);
        if (v.e_req > 0) begin
            check({tag, " mem_addr"}, 32'(a0), 32'(v.e_addr));
            check({tag, " mem_wmask"}, 32'(m0), 32'(v.e_wmask));
            check({tag, " mem_write"}, w0, v.e_write);
            check({tag, " req_stable"}, 32'(stable), 32'd1);
            check({tag, " busy_in_wait"}, 32'(busy_ok), 32'd1);
            check({tag, " wmask_cleared"}, 32'(mem_if.data_mem_wmask), 32'd0);
            check({tag, " write_cleared"}, mem_if.data_mem_write, 32'd0);
        end
        @(negedge clk);
        check({tag, " done_pulse"}, 32'(done), 32'd0);
        check({tag, " no_second_req"}, 32'(mem_if.data_mem_req), 32'd0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; mem_op = MEM_OP_NONE;
        mem_read_type = MEM_RD_WORD; mem_write_mask = MEM_WR_WORD;
        addr = '0; wdata = '0;
        mem_if.data_mem_valid = 1'b0; mem_if.data_mem_read = '0;

        // Loads carry a word mask and stores a word read type on purpose: the
        // unit must judge each operation by its own field only.
        //       op            rt           wm           addr           wdata          word           wait  spam lat req addr     wmask    write          mis to chk rdata
        vecs.push_back(mk(MEM_OP_LOAD,  MEM_RD_BYTE, MEM_WR_WORD, 32'h0000_0103, 32'h0,         32'h80FF_1234, 0,     0, 2, 1, 16'h0100, 4'b0000, 32'h0,         0, 0, 1, 32'hFFFF_FF80));
        vecs.push_back(mk(MEM_OP_NONE,  MEM_RD_WORD, MEM_WR_WORD, 32'h0000_0003, 32'h0,         32'h0,         0,     0, 1, 0, 16'h0000, 4'b0000, 32'h0,         0, 0, 1, 32'hFFFF_FF80));
        vecs.push_back(mk(MEM_OP_STORE, MEM_RD_WORD, MEM_WR_HALF, 32'h0000_0002, 32'h0000_BEEF, 32'h0,         3,     0, 5, 4, 16'h0000, 4'b1100, 32'hBEEF_0000, 0, 0, 0, 32'h0));
        vecs.push_back(mk(MEM_OP_LOAD,  MEM_RD_WORD, MEM_WR_BYTE, 32'h0000_0006, 32'h0,         32'h0,         0,     0, 1, 0, 16'h0000, 4'b0000, 32'h0,         1, 0, 0, 32'h0));
        vecs.push_back(mk(MEM_OP_STORE, MEM_RD_WORD, MEM_WR_BYTE, 32'h0000_0007, 32'h0000_00A5, 32'h0,         0,     0, 2, 1, 16'h0004, 4'b1000, 32'hA500_0000, 0, 0, 0, 32'h0));
        vecs.push_back(mk(MEM_OP_LOAD,  MEM_RD_WORD, MEM_WR_WORD, 32'h0000_0010, 32'h0,         32'h1111_2222, NEVER, 0, 5, 4, 16'h0010, 4'b0000, 32'h0,         0, 1, 1, 32'h0));
        vecs.push_back(mk(MEM_OP_LOAD,  MEM_RD_WORD, MEM_WR_WORD, 32'h0000_0014, 32'h0,         32'hCAFE_F00D, 3,     0, 5, 4, 16'h0014, 4'b0000, 32'h0,         0, 0, 1, 32'hCAFE_F00D));
        vecs.push_back(mk(MEM_OP_LOAD,  MEM_RD_H_U,  MEM_WR_WORD, 32'h0000_0002, 32'h0,         32'h1234_5678, 1,     0, 3, 2, 16'h0000, 4'b0000, 32'h0,         0, 0, 1, 32'h0000_1234));
        vecs.push_back(mk(MEM_OP_LOAD,  MEM_RD_HALF, MEM_WR_WORD, 32'h0000_0002, 32'h0,         32'h8765_0000, 0,     0, 2, 1, 16'h0000, 4'b0000, 32'h0,         0, 0, 1, 32'hFFFF_8765));
        vecs.push_back(mk(MEM_OP_LOAD,  MEM_RD_B_U,  MEM_WR_WORD, 32'h0000_0001, 32'h0,         32'h1234_F0AB, 2,     0, 4, 3, 16'h0000, 4'b0000, 32'h0,         0, 0, 1, 32'h0000_00F0));
        vecs.push_back(mk(MEM_OP_STORE, MEM_RD_WORD, MEM_WR_WORD, 32'h0000_0008, 32'hDEAD_BEEF, 32'h0,         2,     1, 4, 3, 16'h0008, 4'b1111, 32'hDEAD_BEEF, 0, 0, 0, 32'h0));
        vecs.push_back(mk(MEM_OP_STORE, MEM_RD_BYTE, MEM_WR_HALF, 32'h0000_0001, 32'h0000_1234, 32'h0,         0,     0, 1, 0, 16'h0000, 4'b0000, 32'h0,         1, 0, 0, 32'h0));
        vecs.push_back(mk(MEM_OP_LOAD,  MEM_RD_HALF, MEM_WR_BYTE, 32'h0000_0003, 32'h0,         32'h0,         0,     0, 1, 0, 16'h0000, 4'b0000, 32'h0,         1, 0, 0, 32'h0));
        vecs.push_back(mk(MEM_OP_LOAD,  MEM_RD_WORD, MEM_WR_WORD, 32'hABCD_1234, 32'h0,         32'h1122_3344, 1,     1, 3, 2, 16'h1234, 4'b0000, 32'h0,         0, 0, 1, 32'h1122_3344));
        vecs.push_back(mk(MEM_OP_LOAD,  MEM_RD_HALF, MEM_WR_WORD, 32'h0000_0000, 32'h0,         32'hAAAA_7FFF, 0,     0, 2, 1, 16'h0000, 4'b0000, 32'h0,         0, 0, 1, 32'h0000_7FFF));

        // Reset values.
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst rdata", rdata, 32'd0);
        check("rst misaligned", 32'(misaligned), 32'd0);
        check("rst timeout", 32'(timeout), 32'd0);
        check("rst req", 32'(mem_if.data_mem_req), 32'd0);
        check("rst addr", 32'(mem_if.data_mem_addr), 32'd0);
        check("rst wmask", 32'(mem_if.data_mem_wmask), 32'd0);
        check("rst write", mem_if.data_mem_write, 32'd0);

        // Reset while a store waits on memory abandons it.
        @(negedge clk);
        start = 1'b1; mem_op = MEM_OP_STORE; mem_write_mask = MEM_WR_WORD;
        addr = 32'h0000_0020; wdata = 32'h0BAD_F00D;
        @(negedge clk);
        start = 1'b0;
        check("midrst req_before", 32'(mem_if.data_mem_req), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst req", 32'(mem_if.data_mem_req), 32'd0);
        check("midrst busy", 32'(busy), 32'd0);
        check("midrst done", 32'(done), 32'd0);
        check("midrst wmask", 32'(mem_if.data_mem_wmask), 32'd0);
        @(negedge clk);
        check("midrst no_late_done", 32'(done), 32'd0);

        foreach (vecs[i]) run_vec(i, vecs[i]);

        // Memory ack while idle must not start or finish anything.
        mem_if.data_mem_valid = 1'b1; mem_if.data_mem_read = 32'hFFFF_FFFF;
        @(negedge clk);
        mem_if.data_mem_valid = 1'b0;
        check("idle_valid done", 32'(done), 32'd0);
        check("idle_valid req", 32'(mem_if.data_mem_req), 32'd0);
        check("idle_valid busy", 32'(busy), 32'd0);
        check("idle_valid rdata", rdata, 32'h0000_7FFF);
        @(negedge clk);
        check("idle_valid done_later", 32'(done), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_rv32i_lsu

// File: doc/rv32i_lsu.md
# rv32i_lsu

Parametrised load/store unit for the rv32i core.
- Takes one load or store from the core's execute stage and runs a valid/ready-style transaction on the data memory port, stalling for as many cycles as memory needs.
- Aligns store data and byte masks, and shifts and sign- or zero-extends load data.
- Flags misaligned accesses and memory timeouts back to the core, which raises the trap.
- Sits between the core FSM and the data memory. It replaces the fixed single-cycle memory wait with a real handshake and a bounded wait counter.

## Interface
Parameters:
- DMEM_WIDTH, 16, data memory address width in bits.
- MAX_WAIT, 15, number of extra wait cycles tolerated before timeout; legal range 0..255.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high; clock clk.
- start  in  1  core requests an access; sampled only in IDLE.
- mem_op  in  2  MEM_OP_NONE / MEM_OP_LOAD / MEM_OP_STORE.
- mem_read_type  in  3  MEM_RD_BYTE / HALF / B_U / H_U / WORD.
- mem_write_mask  in  4  unshifted store mask: MEM_WR_BYTE (0001), MEM_WR_HALF (0011), MEM_WR_WORD (1111).
- addr  in  32  effective byte address (ALU result).
- wdata  in  32  store data (rs2), right-aligned.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle completion pulse.
- rdata  out  32  extended load result; valid from done, held until the next accepted start.
- misaligned  out  1  access was misaligned; valid with done, held.
- timeout  out  1  memory did not answer; valid with done, held.
- data_mem_req  out  1  request to memory.
- data_mem_addr  out  DMEM_WIDTH  word-aligned address.
- data_mem_wmask  out  4  byte write enables; 0 for loads.
- data_mem_write  out  32  shifted store data; 0 for loads.
- data_mem_read  in  32  memory read word.
- data_mem_valid  in  1  memory ack (load data valid / store committed).

## Operation
FSM states: IDLE, WAIT, DONE.

IDLE: busy=0, req=0. On start:
- mem_op==NONE → DONE. No request; all flags 0; rdata unchanged.
- misaligned → DONE with misaligned=1. No request. Misaligned means HALF/H_U or MEM_WR_HALF with addr[0]=1, or WORD/MEM_WR_WORD with addr[1:0]≠0. Bytes are never misaligned.
- otherwise latch op, type and addr[1:0]; drive request outputs; clear the wait counter; → WAIT.

WAIT: req=1. addr, wmask and write are held stable.
- data_mem_addr = {addr[DMEM_WIDTH-1:2],2'b00}; upper address bits are ignored.
- Store: data_mem_write = wdata << {addr[1:0],3'b000}; data_mem_wmask = mem_write_mask << addr[1:0].
- On data_mem_valid=1: a load captures rdata; → DONE.
- Valid low and counter<MAX_WAIT: counter+1.
- Valid low and counter==MAX_WAIT: timeout=1, rdata=0; → DONE.
- Valid high on the final counter cycle counts as success.

Load extension: s = data_mem_read >> {addr[1:0],3'b000}.
- BYTE: sign-extend s[7:0]. B_U: zero-extend s[7:0].
- HALF: sign-extend s[15:0]. H_U: zero-extend s[15:0].
- WORD: s.

DONE: done=1, busy=0; the req, wmask and write outputs return to 0. → IDLE.

Ignored inputs:
- start while busy or in DONE.
- data_mem_valid outside WAIT.

## Timing
- Reset values: state IDLE and every output 0 (busy, done, rdata, misaligned, timeout, req, addr, wmask, write).
- Reset mid-transaction abandons the access: req=0 and done=0 in the cycle after the reset edge.
- Start accepted at edge E0 → req high from E0. If valid is seen at edge Ek, done is high in the cycle after Ek.
- Zero-wait memory (valid high in the first req cycle): done in the 2nd cycle after start.
- Timeout: req is high for exactly MAX_WAIT+1 cycles; done in the following cycle.
- NONE or misaligned: done in the 1st cycle after start; req never asserted.
- Minimum back-to-back issue: the next start is accepted in the cycle after done.
- Stores also wait for data_mem_valid; no posted writes.

## Structure
- MEM_OP_*, MEM_RD_*, MEM_WR_* come from the shared defines.v. Nothing new is added there.
- State encoding and wait-counter width ($clog2(MAX_WAIT+1), min 1) are local to the block.
- One combinational sub-module, dmem_align, handles store shift/mask, load shift/extend and misalignment detection. It is instantiated once.

## Test plan
- lb, addr 0x0103; memory returns 0x80FF_1234 with valid in the first req cycle → data_mem_addr 0x0100, wmask 0, rdata 0xFFFF_FF80, done 2 cycles after start.
- sh, addr 0x0002, wdata 0x0000_BEEF; valid after 3 wait cycles → write 0xBEEF_0000 and wmask 1100, stable for 4 req cycles; done next cycle, flags 0.
- lw, addr 0x0006 → misaligned=1 with done 1 cycle after start; req never high. Repeat with sb, addr 0x0007 → request issued, wmask 1000.
- MAX_WAIT=3, load, valid never → req high 4 cycles, timeout=1, rdata=0. Second run with valid in the 4th req cycle → success, timeout=0.
- Reset asserted during WAIT → req=0, busy=0 the next cycle. Then lhu addr 0x0002 from 0x1234_5678 → rdata 0x0000_1234; lh from 0x8765_0000 → 0xFFFF_8765.
- start pulsed while busy, and valid pulsed in IDLE → no second transaction, no spurious done.
